z80_region_decoder: RTL
=======================

# z80_region_decoder

Parametrised, run-time programmable memory decoder with per-region wait-state generation for the Z80 system bus. Compares the CPU address against a table of NUM_REGIONS inclusive address ranges, emits one-hot region enables plus the decoded bus strobes, and drives the CPU WAIT line for a programmable number of cycles at the start of each memory access to a slow region. Sits between the CPU and the memory/peripheral fabric. Reset loads the current system memory map, so software that never touches the table runs unchanged.

## Interface
Parameters:
- NUM_REGIONS, 8, number of decode regions (1..16); index 0 has highest priority
- ADDR_W, 16, address width (≥16)
- WAIT_W, 3, width of the per-region wait count

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- addr  in  ADDR_W  CPU address
- rd_n, wr_n, mreq_n, iorq_n, m1_n  in  1 each  Z80 control strobes
- disable_decode  in  1  forces all region enables and hit low
- cfg_we  in  1  table write strobe
- cfg_idx  in  $clog2(NUM_REGIONS) (min 1)  region to write
- cfg_lo, cfg_hi  in  ADDR_W each  inclusive range bounds
- cfg_wait  in  WAIT_W  wait states for region
- cfg_valid  in  1  region enable
- memrd, memwr, iord, iowr, inta  out  1 each  decoded strobes
- region_ena  out  NUM_REGIONS  one-hot (or zero) region select
- region_idx  out  $clog2(NUM_REGIONS) (min 1)  index of winning region, 0 if no hit
- hit  out  1  any region selected
- wait_n  out  1  active-low CPU WAIT
- unmapped_flag  out  1  sticky unmapped-access flag (macro)
- unmapped_addr  out  ADDR_W  address of first unmapped access (macro)
- unmapped_clr  in  1  clears unmapped_flag (macro)

## Operation
- Strobes combinational: memrd=~rd_n&~mreq_n, memwr=~wr_n&~mreq_n, iord=~rd_n&~iorq_n, iowr=~wr_n&~iorq_n, inta=~m1_n&~iorq_n.
- Match i = valid[i] && lo[i] ≤ addr ≤ hi[i] (unsigned). Lowest matching index wins; region_ena has at most one bit set. Combinational from addr and current table. disable_decode=1 → region_ena=0, hit=0, region_idx=0.
- lo>hi means the region never matches.
- Table write: on clk with cfg_we=1, entry cfg_idx takes cfg_lo/hi/wait/valid; visible to decode the following cycle. cfg_idx ≥ NUM_REGIONS ignored.
- Reset table (zero-extended; entries beyond NUM_REGIONS dropped, remainder valid=0, wait=0): 0 ROM 0000–3FFF wait 0; 1 RAM 6000–6BFF; 2 OBJ 7000–73FF; 3 TILE 7400–77FF; 4 DMA 7800–780F; 5 IO 7C00–7DFF; 6 OPORT 7F00–7F00; all wait 0, valid 1.
- acc = memrd|memwr; acc_d = acc registered; start = acc & ~acc_d. I/O and interrupt-acknowledge cycles never generate waits.
- Wait FSM states IDLE, WAIT, HOLD:
  - IDLE: start & hit & wait[region_idx]>0 → WAIT, cnt←wait[region_idx]; start & (no hit or wait=0) → HOLD.
  - WAIT: wait_n=0; cnt decrements each cycle; cnt==1 → HOLD. acc falls → IDLE (abort).
  - HOLD: wait_n=1; acc=0 → IDLE.
- Wait count latched at start; table writes during an access do not affect it.

## Timing
- Reset: FSM IDLE, acc_d=0, wait_n=1, unmapped_flag=0, unmapped_addr=0, table = reset map. Combinational outputs follow inputs immediately after reset.
- wait_n low for exactly W cycles, first low cycle = cycle after the clk edge that samples start.
- Back-to-back accesses need acc low ≥1 sampled cycle to produce a new start.
- rst during WAIT: wait_n high the next cycle, FSM IDLE.
- cfg_we and start same cycle: decode and wait use the old entry.

## Configuration
- Macro REGION_DECODER_UNMAPPED_EN. Defined: on start with hit=0 and disable_decode=0, unmapped_flag←1 and unmapped_addr←addr if flag was 0 (first address kept); unmapped_clr clears flag; set and clr same cycle → set wins, address captured. Undefined: unmapped_flag and unmapped_addr tied 0, unmapped_clr ignored, no capture logic.

## Test plan
- Reset map: addr 0x3FFF memrd → region_ena=0x01, wait_n stays 1; 0x6C00 → hit=0; 0x7F00 → region_ena=0x40, region_idx=6.
- Program region 1 wait=3, read 0x6000 → wait_n low exactly 3 cycles from cycle after start, then HOLD until mreq_n high.
- Overlap: region 0 = 0000–FFFF wait 0, region 2 = 7000–73FF → addr 0x7000 selects region 0 only.
- Abort/reset: wait=7 access, deassert mreq_n after 2 wait cycles → wait_n=1 next cycle; repeat with rst → same; I/O read at 0x6000 → no wait.
- Unmapped (macro on): memrd at 0x5000 then 0x5001 → flag=1, unmapped_addr=0x5000; unmapped_clr with new unmapped start same cycle → flag stays 1, addr updated.

Source files
------------

// File: rtl/z80_region_decoder.sv
// Z80 address-range decoder with a programmable region table and per-region WAIT generation.
// Optional sticky unmapped-access capture is enabled by defining REGION_DECODER_UNMAPPED_EN.
module z80_region_decoder #(
    parameter  int NUM_REGIONS = 8,
    parameter  int ADDR_W      = 16,
    parameter  int WAIT_W      = 3,
    localparam int IDX_W       = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr,
    input  logic              rd_n,
    input  logic              wr_n,
    input  logic              mreq_n,
    input  logic              iorq_n,
    input  logic              m1_n,
    input  logic              disable_decode,
    input  logic              cfg_we,
    input  logic [IDX_W-1:0]  cfg_idx,
    input  logic [ADDR_W-1:0] cfg_lo,
    input  logic [ADDR_W-1:0] cfg_hi,
    input  logic [WAIT_W-1:0] cfg_wait,
    input  logic              cfg_valid,
    output logic              memrd,
    output logic              memwr,
    output logic              iord,
    output logic              iowr,
    output logic              inta,
    output logic [NUM_REGIONS-1:0] region_ena,
    output logic [IDX_W-1:0]  region_idx,
    output logic              hit,
    output logic              wait_n,
    output logic              unmapped_flag,
    output logic [ADDR_W-1:0] unmapped_addr,
    input  logic              unmapped_clr
);

    // state  | meaning
    // S_IDLE | no memory access in progress, waiting for a start
    // S_WAIT | holding WAIT low, cnt = remaining low cycles
    // S_HOLD | access running with WAIT released, wait for acc to drop
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD} state_t;

    state_t            state, state_nxt;
    logic [WAIT_W-1:0] cnt, cnt_nxt;
    logic              acc, acc_d, start;

    logic [ADDR_W-1:0] lo_tbl   [NUM_REGIONS];
    logic [ADDR_W-1:0] hi_tbl   [NUM_REGIONS];
    logic [WAIT_W-1:0] wait_tbl [NUM_REGIONS];
    logic              vld_tbl  [NUM_REGIONS];

    function automatic logic [ADDR_W-1:0] ext(input logic [15:0] v);
        logic [ADDR_W-1:0] r;
        r       = '0;
        r[15:0] = v;
        return r;
    endfunction

    function automatic logic [15:0] map_lo(input int i);
        case (i)
            0:       return 16'h0000;
            1:       return 16'h6000;
            2:       return 16'h7000;
            3:       return 16'h7400;
            4:       return 16'h7800;
            5:       return 16'h7C00;
            6:       return 16'h7F00;
            default: return 16'h0000;
        endcase
    endfunction

    function automatic logic [15:0] map_hi(input int i);
        case (i)
            0:       return 16'h3FFF;
            1:       return 16'h6BFF;
            2:       return 16'h73FF;
            3:       return 16'h77FF;
            4:       return 16'h780F;
            5:       return 16'h7DFF;
            6:       return 16'h7F00;
            default: return 16'h0000;
        endcase
    endfunction

    assign memrd = ~rd_n & ~mreq_n;
    assign memwr = ~wr_n & ~mreq_n;
    assign iord  = ~rd_n & ~iorq_n;
    assign iowr  = ~wr_n & ~iorq_n;
    assign inta  = ~m1_n & ~iorq_n;

    assign acc   = memrd | memwr;
    assign start = acc & ~acc_d;

    // Scan from the top down so the lowest matching index is the one left standing.
    always_comb begin
        region_ena = '0;
        region_idx = '0;
        hit        = 1'b0;
        if (!disable_decode) begin
            for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
                if (vld_tbl[i] && (addr >= lo_tbl[i]) && (addr <= hi_tbl[i])) begin
                    region_ena    = '0;
                    region_ena[i] = 1'b1;
                    region_idx    = IDX_W'(i);
                    hit           = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGIONS; i++) begin
                lo_tbl[i]   <= ext(map_lo(i));
                hi_tbl[i]   <= ext(map_hi(i));
                wait_tbl[i] <= '0;
                vld_tbl[i]  <= (i < 7);
            end
        end else if (cfg_we && (int'(cfg_idx) < NUM_REGIONS)) begin
            lo_tbl[cfg_idx]   <= cfg_lo;
            hi_tbl[cfg_idx]   <= cfg_hi;
            wait_tbl[cfg_idx] <= cfg_wait;
            vld_tbl[cfg_idx]  <= cfg_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
            acc_d <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            acc_d <= acc;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (hit && (wait_tbl[region_idx] != '0)) begin
                        state_nxt = S_WAIT;
                        cnt_nxt   = wait_tbl[region_idx];
                    end else begin
                        state_nxt = S_HOLD;
                    end
                end
            end
            S_WAIT: begin
                if (!acc) begin
                    state_nxt = S_IDLE;
                end else if (cnt == WAIT_W'(1)) begin
                    state_nxt = S_HOLD;
                end else begin
                    cnt_nxt = cnt - WAIT_W'(1);
                end
            end
            S_HOLD: begin
                if (!acc) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign wait_n = (state != S_WAIT);

`ifdef REGION_DECODER_UNMAPPED_EN
    // A fresh unmapped start outranks a same-cycle clear and re-captures the address.
    always_ff @(posedge clk) begin
        if (rst) begin
            unmapped_flag <= 1'b0;
            unmapped_addr <= '0;
        end else if (start && !hit && !disable_decode) begin
            unmapped_flag <= 1'b1;
            if (!unmapped_flag || unmapped_clr) unmapped_addr <= addr;
        end else if (unmapped_clr) begin
            unmapped_flag <= 1'b0;
        end
    end
`else
    logic unused_clr;
    assign unused_clr    = unmapped_clr;
    assign unmapped_flag = 1'b0;
    assign unmapped_addr = '0;
`endif

endmodule
